// File: rtl/operand_stream_sched.sv
// rtl/operand_stream_sched.sv - operand bank scheduler: host write port plus row-major matrix read streamer
module operand_stream_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_DIM    = 4,
  parameter int DIM_WIDTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  host_req_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  output logic                  host_gnt_o,
  input  logic                  start_i,
  input  logic [DIM_WIDTH-1:0]  dim_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  stream_valid_o,
  input  logic                  stream_ready_i,
  output logic [DATA_WIDTH-1:0] stream_data_o,
  output logic                  stream_last_o,
  output logic [ADDR_WIDTH-1:0] mat_addr_o,
  output logic [DATA_WIDTH-1:0] mat_wdata_o,
  output logic                  mat_we_o,
  input  logic [DATA_WIDTH-1:0] mat_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_CAP,
    S_HOLD,
    S_DONE
  } state_e;

  state_e                state_q;
  logic [DIM_WIDTH-1:0]  dim_q;
  logic [DIM_WIDTH-1:0]  row_q;
  logic [DIM_WIDTH-1:0]  col_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  done_q;
  logic                  err_q;

  logic [DIM_WIDTH-1:0]  dim_m1;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  dim_ok;
  logic                  is_idle;
  logic                  at_last;

  // Element address uses the fixed bank stride, not the runtime dim.
  assign dim_m1  = dim_q - DIM_WIDTH'(1);
  assign rd_addr = ADDR_WIDTH'(int'(row_q) * MAX_DIM + int'(col_q));
  assign dim_ok  = (dim_i != '0) && (int'(dim_i) <= MAX_DIM);
  assign is_idle = (state_q == S_IDLE);
  assign at_last = (row_q == dim_m1) && (col_q == dim_m1);

  // Host owns the bank port only while the sequencer is idle; otherwise it stalls.
  assign host_gnt_o  = is_idle & host_req_i;
  assign mat_we_o    = is_idle & host_req_i;
  assign mat_wdata_o = host_wdata_i;
  assign mat_addr_o  = is_idle                 ? host_addr_i :
                       (state_q == S_RD_ADDR)  ? rd_addr     : addr_q;

  assign busy_o         = ~is_idle;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign stream_valid_o = valid_q;
  assign stream_data_o  = data_q;
  assign stream_last_o  = last_q;

  // Sequencer FSM: address, capture registered read data, hold until handshake, advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      dim_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (dim_ok) begin
              dim_q   <= dim_i;
              row_q   <= '0;
              col_q   <= '0;
              state_q <= S_RD_ADDR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          addr_q  <= rd_addr;
          state_q <= S_RD_CAP;
        end
        S_RD_CAP: begin
          data_q  <= mat_rdata_i;
          last_q  <= at_last;
          valid_q <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (stream_ready_i) begin
            valid_q <= 1'b0;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              if (col_q == dim_m1) begin
                col_q <= '0;
                row_q <= row_q + DIM_WIDTH'(1);
              end else begin
                col_q <= col_q + DIM_WIDTH'(1);
              end
              state_q <= S_RD_ADDR;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_stream_sched.sv
// tb/tb_operand_stream_sched.sv - self-checking bench for operand_stream_sched
module tb_operand_stream_sched;

  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int MAX_DIM = 4;
  localparam int DIMW    = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            host_req_i;
  logic [AW-1:0]   host_addr_i;
  logic [DW-1:0]   host_wdata_i;
  logic            host_gnt_o;
  logic            start_i;
  logic [DIMW-1:0] dim_i;
  logic            busy_o;
  logic            done_o;
  logic            err_o;
  logic            stream_valid_o;
  logic            stream_ready_i;
  logic [DW-1:0]   stream_data_o;
  logic            stream_last_o;
  logic [AW-1:0]   mat_addr_o;
  logic [DW-1:0]   mat_wdata_o;
  logic            mat_we_o;
  logic [DW-1:0]   mat_rdata_i;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [DW-1:0] bank   [32];
  logic [DW-1:0] shadow [32];

  always #5 clk_i = ~clk_i;

  operand_stream_sched #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DIM(MAX_DIM), .DIM_WIDTH(DIMW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o),
    .start_i(start_i), .dim_i(dim_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
    .stream_data_o(stream_data_o), .stream_last_o(stream_last_o),
    .mat_addr_o(mat_addr_o), .mat_wdata_o(mat_wdata_o), .mat_we_o(mat_we_o),
    .mat_rdata_i(mat_rdata_i)
  );

  // Operand bank: single port, registered read.
  always @(posedge clk_i) begin
    if (mat_we_o) bank[mat_addr_o] <= mat_wdata_o;
    mat_rdata_i <= bank[mat_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req_i = 1'b1; host_addr_i = a; host_wdata_i = d;
    #1;
    chk("host_gnt_idle", host_gnt_o, 1);
    chk("mat_we_idle", mat_we_o, 1);
    chk("mat_addr_idle", mat_addr_o, 32'(a));
    tick();
    shadow[a] = d;
    host_req_i = 1'b0;
  endtask

  task automatic bad_start(input logic [DIMW-1:0] d);
    start_i = 1'b1; dim_i = d;
    tick();
    start_i = 1'b0;
    chk("err_pulse", err_o, 1);
    chk("err_busy", busy_o, 0);
    chk("err_valid", stream_valid_o, 0);
    tick();
    chk("err_clear", err_o, 0);
    chk("err_busy_after", busy_o, 0);
    chk("err_valid_after", stream_valid_o, 0);
  endtask

  task automatic run_stream(input int d, input int stall_pct, input int stall_elem,
                            input int stall_len, input bit contend, input bit wr_at_start);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] held_data;
    logic [DW-1:0] cwdata;
    logic          held_last;
    logic          rdy;
    bit            was_stalled;
    bit            just_hs;
    int            lat;
    int            got;
    int            cyc;
    int            stall_cnt;
    held_data = '0; held_last = 1'b0;
    start_i = 1'b1; dim_i = 3'(d);
    if (wr_at_start) begin
      host_req_i = 1'b1; host_addr_i = '0; host_wdata_i = 32'hABCD_0000 | 32'($urandom_range(0, 255));
      #1;
      chk("gnt_with_start", host_gnt_o, 1);
    end
    tick();
    start_i = 1'b0;
    if (wr_at_start) begin
      shadow[0] = host_wdata_i;
      host_req_i = 1'b0;
    end
    cwdata = $urandom;
    if (contend) begin
      host_req_i = 1'b1; host_addr_i = 5'd20; host_wdata_i = cwdata;
    end
    for (int r = 0; r < d; r++)
      for (int c = 0; c < d; c++)
        exp_q.push_back(shadow[(r * MAX_DIM + c) % 32]);
    chk("busy_after_start", busy_o, 1);
    lat = 1;
    while (!stream_valid_o && lat < 10) begin
      if (contend) chk("gnt_blocked_lat", host_gnt_o, 0);
      tick();
      lat++;
    end
    chk("first_valid_latency", 32'(lat), 3);
    got = 0; cyc = 0; stall_cnt = 0; was_stalled = 0; just_hs = 0;
    while (got < d * d && cyc < 2000) begin
      if (contend) begin
        chk("gnt_blocked", host_gnt_o, 0);
        chk("we_blocked", mat_we_o, 0);
      end
      if (just_hs) chk("valid_drop_after_hs", stream_valid_o, 0);
      just_hs = 0;
      if (stream_valid_o) begin
        if (was_stalled) begin
          chk("stall_data_stable", stream_data_o, held_data);
          chk("stall_last_stable", stream_last_o, held_last);
        end
        if (got == stall_elem && stall_cnt < stall_len) begin
          rdy = 1'b0;
          stall_cnt++;
        end else begin
          rdy = ($urandom_range(0, 99) >= stall_pct);
        end
        if (rdy) begin
          chk("stream_data", stream_data_o, exp_q[got]);
          chk("stream_last", stream_last_o, 32'(got == d * d - 1));
          got++;
          just_hs = 1;
        end
        held_data = stream_data_o; held_last = stream_last_o; was_stalled = !rdy;
      end else begin
        rdy = 1'($urandom_range(0, 1));
        was_stalled = 0;
      end
      stream_ready_i = rdy;
      tick();
      cyc++;
    end
    stream_ready_i = 1'b0;
    chk("elements_received", 32'(got), 32'(d * d));
    chk("done_pulse", done_o, 1);
    chk("done_valid_low", stream_valid_o, 0);
    chk("done_busy", busy_o, 1);
    if (contend) chk("gnt_blocked_done", host_gnt_o, 0);
    tick();
    chk("done_clear", done_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_valid", stream_valid_o, 0);
    if (contend) begin
      chk("gnt_in_idle", host_gnt_o, 1);
      tick();
      shadow[20] = cwdata;
      host_req_i = 1'b0;
      chk("contend_write_landed", bank[20], cwdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      bank[i] = '0;
      shadow[i] = '0;
    end
    rst_ni = 1'b0; host_req_i = 1'b0; host_addr_i = '0; host_wdata_i = '0;
    start_i = 1'b0; dim_i = '0; stream_ready_i = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", stream_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_data", stream_data_o, 0);
    chk("rst_last", stream_last_o, 0);
    rst_ni = 1'b1;
    tick();

    // Fill the bank with known values.
    for (int i = 0; i < 16; i++) host_write(5'(i), 32'h100 + 32'(i));
    for (int i = 0; i < 16; i++) chk("bank_readback", bank[i], 32'h100 + 32'(i));

    // dim 2, ready always high.
    run_stream(2, 0, -1, 0, 0, 0);
    // dim 4, five-cycle stall on element 3.
    run_stream(4, 0, 3, 5, 0, 0);
    // dim 3 with a host request pending through the stream.
    run_stream(3, 30, -1, 0, 1, 0);
    // Host write in the same cycle as start is visible to the stream.
    run_stream(2, 0, -1, 0, 0, 1);

    // Illegal dimensions.
    bad_start(3'd0);
    bad_start(3'd5);
    bad_start(3'd7);

    // Start while busy is ignored: stream dim 1 with a second start mid-stream.
    start_i = 1'b1; dim_i = 3'd1;
    tick();
    dim_i = 3'd4;
    tick();
    start_i = 1'b0;
    tick();
    chk("busy_start_valid", stream_valid_o, 1);
    chk("busy_start_last", stream_last_o, 1);
    chk("busy_start_data", stream_data_o, shadow[0]);
    stream_ready_i = 1'b1;
    tick();
    stream_ready_i = 1'b0;
    chk("busy_start_done", done_o, 1);
    tick();
    chk("busy_start_idle", busy_o, 0);

    // Reset asserted while holding an element.
    start_i = 1'b1; dim_i = 3'd4;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    chk("pre_reset_valid", stream_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", stream_valid_o, 0);
    chk("mid_rst_data", stream_data_o, 0);
    chk("mid_rst_last", stream_last_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    tick();
    chk("mid_rst_done_hold", done_o, 0);
    rst_ni = 1'b1;
    tick();
    chk("post_rst_done", done_o, 0);
    chk("post_rst_busy", busy_o, 0);
    run_stream(2, 20, -1, 0, 0, 0);

    // Randomised rounds: random bank contents, dims and backpressure.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 4; k++) host_write(5'($urandom_range(0, 15)), $urandom);
      run_stream($urandom_range(1, MAX_DIM), $urandom_range(0, 60), -1, 0, 0, 0);
      bad_start(3'($urandom_range(5, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
